slave_tt_core_oci_dct_packer: RTL and testbench

//  Upstream data-trace compression stage of the TT_Core OCI block. It packs 2-bit trace

---
 rtl/slave_tt_core_oci_pkg.sv | 29 ++
 rtl/slave_tt_core_oci_dct_outreg.sv | 50 +++++
 rtl/slave_tt_core_oci_dct_packer.sv | 149 ++++++++++++++
 tb/tb_slave_tt_core_oci_dct_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_tt_core_oci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slave_tt_core_oci_pkg
// Purpose  : Shared constants, atom codes and state encoding for the TT_Core
//            OCI data-trace packer.
// Revision : 1.0 - initial release
// ============================================================================
package slave_tt_core_oci_pkg;

    localparam int ATOM_W       = 2;
    localparam int SLOTS        = 15;
    localparam int DCT_W        = 30;
    localparam int DCT_CNT_W    = 4;
    localparam int IDLE_TIMEOUT = 16;
    localparam int IDLE_CNT_W   = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [ATOM_W-1:0] ATOM_NOP  = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_E    = 2'b01;
    localparam logic [ATOM_W-1:0] ATOM_N    = 2'b10;
    localparam logic [ATOM_W-1:0] ATOM_SYNC = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_FLUSH = 2'b01,
        ST_ENDED = 2'b10
    } dct_state_t;

endpackage
`default_nettype wire

// File: rtl/slave_tt_core_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
// Module   : slave_tt_core_oci_dct_outreg
// Purpose  : Single-entry valid/ready output register with load strobe; the
//            word is held unchanged while the sink stalls.
// Revision : 1.0 - initial release
// ============================================================================
module slave_tt_core_oci_dct_outreg #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_count,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    // Free when empty or when the current word leaves on this edge.
    assign o_free = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_count <= i_count;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/slave_tt_core_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : slave_tt_core_oci_dct_packer
// Purpose  : Packs 2-bit trace atoms into 30-bit words and runs the
//            end-of-test flush. Optional idle-timeout partial flush is
//            enabled by defining SLAVE_TT_CORE_DCT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module slave_tt_core_oci_dct_packer
    import slave_tt_core_oci_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [ATOM_W-1:0]    in_atom,
    output logic                 in_ready,
    input  logic                 test_end_req,
    output logic [DCT_W-1:0]     dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 dct_valid,
    input  logic                 dct_ready,
    output logic                 test_ending,
    output logic                 test_has_ended
);

    localparam logic [DCT_CNT_W-1:0] c_slots = DCT_CNT_W'(SLOTS);

    dct_state_t           r_state;
    logic [DCT_W-1:0]     r_acc;
    logic [DCT_CNT_W-1:0] r_acc_cnt;
    logic                 r_in_ready;
    logic                 r_test_ending;
    logic                 r_test_has_ended;

    logic [DCT_W-1:0]     w_acc_after;
    logic [DCT_CNT_W-1:0] w_cnt_after;
    logic [DCT_W-1:0]     w_acc_next;
    logic [DCT_CNT_W-1:0] w_cnt_next;
    logic                 w_accept;
    logic                 w_flush;
    logic                 w_timeout;
    logic                 w_load;
    logic                 w_out_valid;
    logic                 w_out_free;
    logic                 w_out_valid_next;

    assign w_accept = in_valid && r_in_ready;

    always_comb begin
        w_acc_after = r_acc;
        for (int i = 0; i < SLOTS; i++) begin
            if (w_accept && (r_acc_cnt == DCT_CNT_W'(i))) begin
                w_acc_after[i*ATOM_W +: ATOM_W] = in_atom;
            end
        end
        w_cnt_after = r_acc_cnt + {{(DCT_CNT_W-1){1'b0}}, w_accept};
    end

    // A word completed this cycle transfers on the same edge it fills.
    assign w_flush = (r_state == ST_FLUSH) || w_timeout;
    assign w_load  = w_out_free &&
                     ((w_cnt_after == c_slots) || (w_flush && (w_cnt_after != '0)));

    assign w_acc_next       = w_load ? '0 : w_acc_after;
    assign w_cnt_next       = w_load ? '0 : w_cnt_after;
    assign w_out_valid_next = w_load || (w_out_valid && !dct_ready);

`ifdef SLAVE_TT_CORE_DCT_TIMEOUT_EN
    logic [IDLE_CNT_W-1:0] r_idle_cnt;

    assign w_timeout = (r_state == ST_RUN) &&
                       (r_idle_cnt == IDLE_CNT_W'(IDLE_TIMEOUT));

    // Saturates at the limit so a stalled sink keeps the flush request alive.
    always_ff @(posedge clk) begin
        if (reset || w_accept || w_load) begin
            r_idle_cnt <= '0;
        end else if ((r_state == ST_RUN) && (r_acc_cnt != '0) && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_acc            <= '0;
            r_acc_cnt        <= '0;
            r_in_ready       <= 1'b0;
            r_test_ending    <= 1'b0;
            r_test_has_ended <= 1'b0;
        end else begin
            r_acc     <= w_acc_next;
            r_acc_cnt <= w_cnt_next;
            case (r_state)
                ST_RUN: begin
                    if (test_end_req) begin
                        r_state       <= ST_FLUSH;
                        r_in_ready    <= 1'b0;
                        r_test_ending <= 1'b1;
                    end else begin
                        r_in_ready <= (w_cnt_next != c_slots);
                    end
                end
                ST_FLUSH: begin
                    if ((w_cnt_next == '0) && !w_out_valid_next) begin
                        r_state          <= ST_ENDED;
                        r_test_ending    <= 1'b0;
                        r_test_has_ended <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    r_state <= ST_ENDED;
                end
                default: begin
                    r_state          <= ST_RUN;
                    r_in_ready       <= 1'b0;
                    r_test_ending    <= 1'b0;
                    r_test_has_ended <= 1'b0;
                end
            endcase
        end
    end

    slave_tt_core_oci_dct_outreg #(
        .DATA_W (DCT_W),
        .CNT_W  (DCT_CNT_W)
    ) u_outreg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_data  (w_acc_after),
        .i_count (w_cnt_after),
        .i_ready (dct_ready),
        .o_valid (w_out_valid),
        .o_data  (dct_buffer),
        .o_count (dct_count),
        .o_free  (w_out_free)
    );

    assign dct_valid      = w_out_valid;
    assign in_ready       = r_in_ready;
    assign test_ending    = r_test_ending;
    assign test_has_ended = r_test_has_ended;

endmodule
`default_nettype wire

// File: tb/tb_slave_tt_core_oci_dct_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_slave_tt_core_oci_dct_packer
// Purpose  : Self-checking bench: atom-queue scoreboard plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slave_tt_core_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_atom = 2'b00;
    logic        test_end_req = 1'b0;
    logic        dct_ready = 1'b0;
    logic        in_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        test_ending;
    logic        test_has_ended;

`ifdef SLAVE_TT_CORE_DCT_TIMEOUT_EN
    localparam bit TMO_BUILD = 1'b1;
`else
    localparam bit TMO_BUILD = 1'b0;
`endif

    slave_tt_core_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_atom        (in_atom),
        .in_ready       (in_ready),
        .test_end_req   (test_end_req),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int words = 0;

    logic [1:0]  q[$];
    bit          prev_stall = 1'b0;
    logic [29:0] prev_buf;
    logic [3:0]  prev_cnt;
    int          m_n;
    logic [29:0] m_exp;
    bit          m_okq;
    bit          m_pok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every emitted word must be the next dct_count accepted atoms,
    // oldest in slot 0, zeros above; short words only during flush or timeout.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_data", {2'b00, dct_buffer}, {2'b00, prev_buf});
                check("hold_valid_count", {27'd0, dct_valid, dct_count}, {27'd0, 1'b1, prev_cnt});
            end
            if (dct_valid && dct_ready) begin
                m_n   = int'(dct_count);
                m_exp = '0;
                m_okq = (m_n >= 1) && (q.size() >= m_n);
                m_pok = (m_n == 15) || test_ending || TMO_BUILD;
                if (m_okq) begin
                    for (int i = 0; i < m_n; i++) m_exp[2*i +: 2] = q[i];
                end
                check("word_data", {2'b00, dct_buffer}, {2'b00, m_exp});
                check("word_count_legal", {30'd0, m_okq, m_pok}, 32'd3);
                if (m_okq) begin
                    for (int i = 0; i < m_n; i++) void'(q.pop_front());
                end
                words++;
            end
            if (in_valid && in_ready) q.push_back(in_atom);
            if (test_ending || test_has_ended)
                check("in_ready_closed", {31'd0, in_ready}, 32'd0);
            prev_stall = dct_valid && !dct_ready;
            prev_buf   = dct_buffer;
            prev_cnt   = dct_count;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; test_end_req = 1'b0; dct_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 10) begin step(); k++; end
        check("in_ready_up", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [1:0] a, input int budget);
        int k = 0;
        in_valid = 1'b1;
        in_atom  = a;
        while (!in_ready && k < budget) begin step(); k++; end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, accepted, w0, idx;
        bit dropped, seen;
        logic [3:0]  got_cnt;
        logic [29:0] got_buf;

        // Reset values
        step(); step();
        check("rst_outputs", {26'd0, dct_valid, in_ready, test_ending, test_has_ended, dct_count == 4'd0, dct_buffer == 30'd0},
              32'd3);

        // 1: full word, back-to-back, sink always ready
        do_reset(); wait_ready();
        dct_ready = 1'b1; dropped = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!in_ready) dropped = 1'b1;
            send(2'b01, 5);
        end
        check("t1_in_ready_held", {31'd0, dropped}, 32'd0);
        check("t1_valid", {31'd0, dct_valid}, 32'd1);
        check("t1_buf", {2'b00, dct_buffer}, 32'h15555555);
        check("t1_cnt", {28'd0, dct_count}, 32'd15);
        step();
        check("t1_in_ready_after", {31'd0, in_ready}, 32'd1);

        // 2: back-pressure with two full words
        do_reset(); wait_ready();
        dct_ready = 1'b0; w0 = words; accepted = 0; k = 0;
        while (accepted < 30 && k < 100) begin
            in_valid = 1'b1; in_atom = 2'($urandom);
            if (in_ready) accepted++;
            step(); k++;
        end
        in_valid = 1'b0;
        check("t2_accepted", accepted, 32'd30);
        check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("t2_valid", {31'd0, dct_valid}, 32'd1);
        step(); step();
        check("t2_in_ready_still_low", {31'd0, in_ready}, 32'd0);
        dct_ready = 1'b1; k = 0;
        while ((words - w0) < 2 && k < 10) begin step(); k++; end
        check("t2_words", words - w0, 32'd2);
        step();
        check("t2_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("t2_drained", q.size(), 32'd0);

        // 3: partial flush of three atoms
        do_reset(); wait_ready();
        dct_ready = 1'b1;
        send(2'b11, 5); send(2'b10, 5); send(2'b01, 5);
        test_end_req = 1'b1; step(); test_end_req = 1'b0;
        check("t3_ending", {31'd0, test_ending}, 32'd1);
        k = 0;
        while (!dct_valid && k < 5) begin step(); k++; end
        check("t3_valid", {31'd0, dct_valid}, 32'd1);
        check("t3_buf", {2'b00, dct_buffer}, 32'h1B);
        check("t3_cnt", {28'd0, dct_count}, 32'd3);
        check("t3_ending_during", {31'd0, test_ending}, 32'd1);
        k = 0;
        while (!test_has_ended && k < 5) begin step(); k++; end
        check("t3_ended", {31'd0, test_has_ended}, 32'd1);
        check("t3_ending_off", {31'd0, test_ending}, 32'd0);
        check("t3_queue_empty", q.size(), 32'd0);

        // 4: flush with nothing buffered, then ENDED ignores requests
        do_reset(); wait_ready();
        seen = 1'b0;
        test_end_req = 1'b1; step(); test_end_req = 1'b0;
        if (dct_valid) seen = 1'b1;
        if (!test_has_ended) begin step(); if (dct_valid) seen = 1'b1; end
        check("t4_ended_in_2", {31'd0, test_has_ended}, 32'd1);
        check("t4_no_word", {31'd0, seen}, 32'd0);
        in_valid = 1'b1; test_end_req = 1'b1; step(); step();
        test_end_req = 1'b0; in_valid = 1'b0;
        check("t4_sticky", {29'd0, test_has_ended, test_ending, in_ready}, 32'd4);

        // 5: reset discards a pending word and a partial accumulator
        do_reset(); wait_ready();
        dct_ready = 1'b0;
        for (int i = 0; i < 22; i++) send(2'($urandom), 10);
        check("t5_valid_before", {31'd0, dct_valid}, 32'd1);
        reset = 1'b1; step();
        check("t5_rst_flags", {28'd0, dct_valid, in_ready, test_ending, test_has_ended}, 32'd0);
        check("t5_rst_buf", {2'b00, dct_buffer}, 32'd0);
        check("t5_rst_cnt", {28'd0, dct_count}, 32'd0);
        reset = 1'b0; step();
        check("t5_in_ready_rise", {31'd0, in_ready}, 32'd1);
        dct_ready = 1'b1;
        for (int i = 0; i < 15; i++) send(2'b10, 5);
        check("t5_post_buf", {2'b00, dct_buffer}, 32'h2AAAAAAA);
        check("t5_post_cnt", {28'd0, dct_count}, 32'd15);

        // 6: idle timeout partial flush (only in the timeout build)
        do_reset(); wait_ready();
        dct_ready = 1'b1;
        send(2'b01, 5); send(2'b11, 5);
        seen = 1'b0; idx = -1; got_cnt = '0; got_buf = '0;
        for (int i = 0; i < 24; i++) begin
            if (dct_valid && !seen) begin
                seen = 1'b1; idx = i; got_cnt = dct_count; got_buf = dct_buffer;
            end
            step();
        end
        check("t6_emitted", {31'd0, seen}, {31'd0, TMO_BUILD});
`ifdef SLAVE_TT_CORE_DCT_TIMEOUT_EN
        check("t6_cnt", {28'd0, got_cnt}, 32'd2);
        check("t6_buf", {2'b00, got_buf}, 32'hD);
        check("t6_delay_window", {31'd0, (idx >= 16) && (idx <= 18)}, 32'd1);
`endif

        // Randomized traffic, then flush and confirm everything drained
        do_reset(); wait_ready();
        w0 = words;
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_atom   = 2'($urandom);
            dct_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        in_valid = 1'b0;
        test_end_req = 1'b1; step(); test_end_req = 1'b0;
        k = 0;
        while (!test_has_ended && k < 100) begin
            dct_ready = 1'($urandom_range(0, 1));
            step(); k++;
        end
        check("rand_ended", {31'd0, test_has_ended}, 32'd1);
        check("rand_queue_empty", q.size(), 32'd0);
        check("rand_enough_words", {31'd0, (words - w0) >= 40}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
